// File: rtl/alu_pkg.sv
// Shared op and state encodings for the lockstep ALU pair.
package alu_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_OK       = 2'b00,
        ST_DEGRADED = 2'b01,
        ST_FAULT    = 2'b10
    } state_e;

    // Wide enough for any threshold up to 255.
    localparam int unsigned CONSEC_W = 8;

endpackage

// File: rtl/alu_lockstep_pair_alu_core.sv
// Combinational WIDTH-bit ALU: ADD/SUB with carry/borrow, AND/OR with carry 0.
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  alu_op_e          sel_i,
    output logic [WIDTH-1:0] result_c_o,
    output logic             carry_c_o
);

    logic [WIDTH:0] sum_c;

    // Borrow of A-B appears in the extra top bit when A < B.
    always_comb begin
        sum_c      = '0;
        result_c_o = '0;
        carry_c_o  = 1'b0;
        case (sel_i)
            ALU_ADD: begin
                sum_c      = {1'b0, a_i} + {1'b0, b_i};
                result_c_o = sum_c[WIDTH-1:0];
                carry_c_o  = sum_c[WIDTH];
            end
            ALU_SUB: begin
                sum_c      = {1'b0, a_i} - {1'b0, b_i};
                result_c_o = sum_c[WIDTH-1:0];
                carry_c_o  = sum_c[WIDTH];
            end
            ALU_AND: result_c_o = a_i & b_i;
            ALU_OR:  result_c_o = a_i | b_i;
            default: result_c_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_lockstep_pair.sv
// Dual ALU in a 2-stage pipeline with lockstep compare, saturating error
// counter and a consecutive-mismatch OK/DEGRADED/FAULT state machine.
module alu_lockstep_pair
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH        = 4,
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned FAULT_THRESH = 3
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             in_valid,
    input  logic             lockstep,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic [1:0]       sel1,
    input  logic [1:0]       sel2,
    input  logic [WIDTH-1:0] fault_inj,
    input  logic             clr_err,
    output logic             out_valid,
    output logic [WIDTH-1:0] alu_out1,
    output logic [WIDTH-1:0] alu_out2,
    output logic             carry1,
    output logic             carry2,
    output logic [WIDTH-1:0] diff_x,
    output logic             diff_y,
    output logic             mismatch,
    output logic [CNT_W-1:0] err_cnt,
    output logic             fault
);

    localparam logic [CONSEC_W:0]   THRESH_EXT = (CONSEC_W+1)'(FAULT_THRESH);
    localparam logic [CONSEC_W-1:0] THRESH_SAT = CONSEC_W'(FAULT_THRESH);

    logic [WIDTH-1:0] a2_c, b2_c, res1_c, res2_c;
    alu_op_e          op2_c;
    logic             c1_c, c2_c;

    // In lockstep ALU2 mirrors ALU1's operands and op.
    assign a2_c  = lockstep ? a0 : a1;
    assign b2_c  = lockstep ? b0 : b1;
    assign op2_c = lockstep ? alu_op_e'(sel1) : alu_op_e'(sel2);

    alu_core #(.WIDTH(WIDTH)) u_alu1 (
        .a_i        (a0),
        .b_i        (b0),
        .sel_i      (alu_op_e'(sel1)),
        .result_c_o (res1_c),
        .carry_c_o  (c1_c)
    );

    alu_core #(.WIDTH(WIDTH)) u_alu2 (
        .a_i        (a2_c),
        .b_i        (b2_c),
        .sel_i      (op2_c),
        .result_c_o (res2_c),
        .carry_c_o  (c2_c)
    );

    logic             v_s1_q, ls_s1_q, c1_s1_q, c2_s1_q;
    logic [WIDTH-1:0] r1_s1_q, r2_s1_q;

    // Stage 1: injection flips ALU2's result bits only, never its carry.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            v_s1_q  <= 1'b0;
            ls_s1_q <= 1'b0;
            r1_s1_q <= '0;
            r2_s1_q <= '0;
            c1_s1_q <= 1'b0;
            c2_s1_q <= 1'b0;
        end else begin
            v_s1_q <= in_valid;
            if (in_valid) begin
                ls_s1_q <= lockstep;
                r1_s1_q <= res1_c;
                r2_s1_q <= res2_c ^ fault_inj;
                c1_s1_q <= c1_c;
                c2_s1_q <= c2_c;
            end
        end
    end

    logic [WIDTH-1:0] diff_x_c;
    logic             diff_y_c, cmp_beat_c, mm_c;

    assign diff_x_c   = r1_s1_q ^ r2_s1_q;
    assign diff_y_c   = c1_s1_q ^ c2_s1_q;
    assign cmp_beat_c = v_s1_q & ls_s1_q;
    assign mm_c       = cmp_beat_c & ((|diff_x_c) | diff_y_c);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;
    logic [CONSEC_W-1:0] consec_q, consec_d;
    logic [CONSEC_W:0]   consec_inc_c;
    logic                hit_thresh_c;

    assign consec_inc_c = {1'b0, consec_q} + (CONSEC_W+1)'(1);
    assign hit_thresh_c = consec_inc_c >= THRESH_EXT;

    // Next-state: clear has priority over a coinciding compared beat.
    always_comb begin
        state_d   = state_q;
        err_cnt_d = err_cnt_q;
        consec_d  = consec_q;
        if (clr_err) begin
            state_d   = ST_OK;
            err_cnt_d = '0;
            consec_d  = '0;
        end else if (cmp_beat_c) begin
            if (mm_c) begin
                if (err_cnt_q != {CNT_W{1'b1}}) begin
                    err_cnt_d = err_cnt_q + CNT_W'(1);
                end
                consec_d = hit_thresh_c ? THRESH_SAT : consec_inc_c[CONSEC_W-1:0];
                if (state_q != ST_FAULT) begin
                    state_d = hit_thresh_c ? ST_FAULT : ST_DEGRADED;
                end
            end else begin
                consec_d = '0;
                if (state_q == ST_DEGRADED) begin
                    state_d = ST_OK;
                end
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= ST_OK;
            err_cnt_q <= '0;
            consec_q  <= '0;
            fault     <= 1'b0;
        end else begin
            state_q   <= state_d;
            err_cnt_q <= err_cnt_d;
            consec_q  <= consec_d;
            fault     <= (state_d == ST_FAULT);
        end
    end

    assign err_cnt = err_cnt_q;

    // Stage 2: data outputs hold across bubbles; mismatch only on valid beats.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            out_valid <= 1'b0;
            alu_out1  <= '0;
            alu_out2  <= '0;
            carry1    <= 1'b0;
            carry2    <= 1'b0;
            diff_x    <= '0;
            diff_y    <= 1'b0;
            mismatch  <= 1'b0;
        end else begin
            out_valid <= v_s1_q;
            mismatch  <= mm_c;
            if (v_s1_q) begin
                alu_out1 <= r1_s1_q;
                alu_out2 <= r2_s1_q;
                carry1   <= c1_s1_q;
                carry2   <= c2_s1_q;
                diff_x   <= diff_x_c;
                diff_y   <= diff_y_c;
            end
        end
    end

endmodule

// File: tb/tb_alu_lockstep_pair.sv
// Scoreboard bench: directed beats push hand-computed expectations, a monitor pops on out_valid.
module tb_alu_lockstep_pair;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst, in_valid, lockstep, clr_err;
    logic [W-1:0] a0, b0, a1, b1, fault_inj;
    logic [1:0]   sel1, sel2;

    logic         out_valid, carry1, carry2, diff_y, mismatch, fault;
    logic [W-1:0] alu_out1, alu_out2, diff_x;
    logic [7:0]   err_cnt;

    logic         d2_out_valid, d2_carry1, d2_carry2, d2_diff_y, d2_mismatch, d2_fault;
    logic [W-1:0] d2_alu_out1, d2_alu_out2, d2_diff_x;
    logic [1:0]   d2_err_cnt;

    always #5 clk = ~clk;

    alu_lockstep_pair #(.WIDTH(W), .CNT_W(8), .FAULT_THRESH(3)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .in_valid(in_valid), .lockstep(lockstep),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1), .sel1(sel1), .sel2(sel2),
        .fault_inj(fault_inj), .clr_err(clr_err), .out_valid(out_valid),
        .alu_out1(alu_out1), .alu_out2(alu_out2), .carry1(carry1), .carry2(carry2),
        .diff_x(diff_x), .diff_y(diff_y), .mismatch(mismatch), .err_cnt(err_cnt),
        .fault(fault)
    );

    // Same stimulus into a 2-bit-counter copy to exercise saturation.
    alu_lockstep_pair #(.WIDTH(W), .CNT_W(2), .FAULT_THRESH(3)) dut2 (
        .wb_clk_i(clk), .wb_rst_i(rst), .in_valid(in_valid), .lockstep(lockstep),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1), .sel1(sel1), .sel2(sel2),
        .fault_inj(fault_inj), .clr_err(clr_err), .out_valid(d2_out_valid),
        .alu_out1(d2_alu_out1), .alu_out2(d2_alu_out2), .carry1(d2_carry1), .carry2(d2_carry2),
        .diff_x(d2_diff_x), .diff_y(d2_diff_y), .mismatch(d2_mismatch), .err_cnt(d2_err_cnt),
        .fault(d2_fault)
    );

    typedef struct {
        logic         v, ls;
        logic [W-1:0] a0, b0, a1, b1, inj;
        logic [1:0]   s1, s2;
        logic         clr;
        logic [W-1:0] r1, r2;
        logic         c1, c2, mm, flt;
        int           cnt;
    } vec_t;

    typedef struct {
        int           cyc;
        logic [W-1:0] r1, r2, dx;
        logic         c1, c2, dy, mm, flt;
        int           cnt;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    exp_t last;
    bit   have_last = 0;
    bit   mon_en = 0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, expv);
        end
    endtask

    function automatic void add(input logic v, input logic ls,
                                input logic [W-1:0] va0, input logic [W-1:0] vb0, input logic [1:0] s1,
                                input logic [W-1:0] va1, input logic [W-1:0] vb1, input logic [1:0] s2,
                                input logic [W-1:0] inj, input logic clr,
                                input logic [W-1:0] r1, input logic c1,
                                input logic [W-1:0] r2, input logic c2,
                                input logic mm, input int cnt, input logic flt);
        vec_t t;
        t.v = v; t.ls = ls; t.a0 = va0; t.b0 = vb0; t.s1 = s1;
        t.a1 = va1; t.b1 = vb1; t.s2 = s2; t.inj = inj; t.clr = clr;
        t.r1 = r1; t.c1 = c1; t.r2 = r2; t.c2 = c2; t.mm = mm; t.cnt = cnt; t.flt = flt;
        vecs.push_back(t);
    endfunction

    // Monitor: pops on out_valid; between beats checks mismatch=0 and held data.
    always @(negedge clk) begin
        if (mon_en) begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("latency", 32'(cyc), 32'(e.cyc + 2));
                    chk("alu_out1", 32'(alu_out1), 32'(e.r1));
                    chk("alu_out2", 32'(alu_out2), 32'(e.r2));
                    chk("carry1", 32'(carry1), 32'(e.c1));
                    chk("carry2", 32'(carry2), 32'(e.c2));
                    chk("diff_x", 32'(diff_x), 32'(e.dx));
                    chk("diff_y", 32'(diff_y), 32'(e.dy));
                    chk("mismatch", 32'(mismatch), 32'(e.mm));
                    chk("err_cnt", 32'(err_cnt), 32'(e.cnt));
                    chk("fault", 32'(fault), 32'(e.flt));
                    chk("sat_out_valid", 32'(d2_out_valid), 32'd1);
                    chk("sat_err_cnt", 32'(d2_err_cnt), 32'((e.cnt > 3) ? 3 : e.cnt));
                    chk("sat_fault", 32'(d2_fault), 32'(e.flt));
                    last = e;
                    have_last = 1;
                end
            end else begin
                chk("bubble_mismatch", 32'(mismatch), 32'd0);
                if (have_last) begin
                    chk("hold_alu_out1", 32'(alu_out1), 32'(last.r1));
                    chk("hold_diff_x", 32'(diff_x), 32'(last.dx));
                end
            end
        end
    end

    task automatic drive(input vec_t t, input logic clr);
        in_valid  = t.v;
        lockstep  = t.ls;
        a0 = t.a0; b0 = t.b0; sel1 = t.s1;
        a1 = t.a1; b1 = t.b1; sel2 = t.s2;
        fault_inj = t.inj;
        clr_err   = clr;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t idle;
        exp_t e;
        bit   drained;

        // v ls a0 b0 s1 a1 b1 s2 inj clr | r1 c1 r2 c2 mm cnt flt
        add(1,1, 4'hF,4'h1,2'b00, 4'h0,4'h0,2'b00, 4'h0,0, 4'h0,1, 4'h0,1, 0, 0,0);
        add(1,0, 4'h3,4'h5,2'b01, 4'h3,4'h5,2'b11, 4'h0,0, 4'hE,1, 4'h7,0, 0, 0,0);
        add(0,0, 4'h0,4'h0,2'b00, 4'h0,4'h0,2'b00, 4'h0,0, 4'h0,0, 4'h0,0, 0, 0,0);
        add(1,1, 4'h2,4'h3,2'b00, 4'h0,4'h0,2'b00, 4'h1,0, 4'h5,0, 4'h4,0, 1, 1,0);
        add(1,1, 4'h9,4'h8,2'b00, 4'h0,4'h0,2'b00, 4'h1,0, 4'h1,1, 4'h0,1, 1, 2,0);
        add(1,1, 4'h2,4'h3,2'b01, 4'h0,4'h0,2'b00, 4'h0,0, 4'hF,1, 4'hF,1, 0, 2,0);
        add(1,1, 4'h6,4'h3,2'b10, 4'h0,4'h0,2'b00, 4'h1,0, 4'h2,0, 4'h3,0, 1, 3,0);
        add(1,1, 4'h5,4'hA,2'b11, 4'h0,4'h0,2'b00, 4'h1,0, 4'hF,0, 4'hE,0, 1, 4,0);
        add(1,1, 4'h7,4'h7,2'b01, 4'h0,4'h0,2'b00, 4'h1,0, 4'h0,0, 4'h1,0, 1, 5,1);
        add(1,1, 4'h1,4'h1,2'b00, 4'h0,4'h0,2'b00, 4'h0,0, 4'h2,0, 4'h2,0, 0, 5,1);
        add(1,1, 4'h4,4'h4,2'b10, 4'hF,4'hF,2'b11, 4'h0,0, 4'h4,0, 4'h4,0, 0, 5,1);
        add(1,1, 4'h1,4'h2,2'b00, 4'h0,4'h0,2'b00, 4'h8,1, 4'h3,0, 4'hB,0, 1, 0,0);
        add(1,1, 4'h1,4'h2,2'b00, 4'h0,4'h0,2'b00, 4'h0,0, 4'h3,0, 4'h3,0, 0, 0,0);
        for (int k = 1; k <= 6; k++) begin
            add(1,1, 4'h3,4'h3,2'b00, 4'h0,4'h0,2'b00, 4'h2,0, 4'h6,0, 4'h4,0, 1, k, (k >= 3) ? 1'b1 : 1'b0);
        end
        add(1,1, 4'h3,4'h3,2'b00, 4'h0,4'h0,2'b00, 4'h0,0, 4'h6,0, 4'h6,0, 0, 6,1);
        add(1,0, 4'h8,4'h8,2'b00, 4'h8,4'h8,2'b01, 4'h0,0, 4'h0,1, 4'h0,0, 0, 6,1);

        idle = vecs[2];

        // Reset with random inputs, including in_valid and clr_err.
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; lockstep = 1'($urandom);
            a0 = W'($urandom); b0 = W'($urandom); a1 = W'($urandom); b1 = W'($urandom);
            sel1 = 2'($urandom); sel2 = 2'($urandom); fault_inj = W'($urandom);
            clr_err = 1'($urandom);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_alu_out1", 32'(alu_out1), 32'd0);
        chk("rst_alu_out2", 32'(alu_out2), 32'd0);
        chk("rst_carries", 32'({carry1, carry2, diff_y, mismatch}), 32'd0);
        chk("rst_diff_x", 32'(diff_x), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        drive(idle, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_out_valid", 32'(out_valid), 32'd0);
        end
        mon_en = 1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk); #1;
            drive(vecs[i], (i > 0) ? vecs[i-1].clr : 1'b0);
            if (vecs[i].v) begin
                e.cyc = cyc;
                e.r1 = vecs[i].r1; e.r2 = vecs[i].r2;
                e.c1 = vecs[i].c1; e.c2 = vecs[i].c2;
                e.dx = vecs[i].r1 ^ vecs[i].r2;
                e.dy = vecs[i].c1 ^ vecs[i].c2;
                e.mm = vecs[i].mm; e.cnt = vecs[i].cnt; e.flt = vecs[i].flt;
                sb.push_back(e);
            end
        end
        @(posedge clk); #1;
        drive(idle, vecs[vecs.size()-1].clr);

        drained = 0;
        for (int i = 0; i < 20 && !drained; i++) begin
            @(negedge clk);
            if (sb.size() == 0) drained = 1;
        end
        chk("drain_remaining", 32'(sb.size()), 32'd0);

        // Reset mid-pipeline: an in-flight mismatch beat must never emerge.
        @(posedge clk); #1;
        mon_en = 0;
        drive(vecs[3], 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        drive(idle, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("flush_out_valid", 32'(out_valid), 32'd0);
        end
        chk("flush_err_cnt", 32'(err_cnt), 32'd0);
        chk("flush_fault", 32'(fault), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_lockstep_pair.md
Name: alu_lockstep_pair

Overview:
- Parametrised successor to the fixed 4-bit dual-ALU compare block in the user project area.
- Two WIDTH-bit ALUs run in a registered 2-stage pipeline. Each result is XOR-compared against the other.
- Adds a lockstep mode, a fault-injection mask, a saturating mismatch counter and a consecutive-mismatch fault state machine.
- Driven from io_in/LA by the macro wrapper. Results return on buf_io_out/LA.

Parameters:
- WIDTH, 4, operand/result width (>=2).
- CNT_W, 8, width of the saturating mismatch counter.
- FAULT_THRESH, 3, consecutive compared mismatches that enter FAULT (1..255).

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  synchronous active-high reset.
- in_valid  in  1  operand set valid this cycle.
- lockstep  in  1  1 = ALU2 uses A0/B0/sel1 and results are compared; 0 = independent, no compare.
- a0, b0  in  WIDTH  ALU1 operands.
- a1, b1  in  WIDTH  ALU2 operands (ignored when lockstep=1).
- sel1, sel2  in  2  op select: 00 ADD, 01 SUB, 10 AND, 11 OR.
- fault_inj  in  WIDTH  XORed into ALU2 result before stage-1 register (test only).
- clr_err  in  1  clears counters and FAULT.
- out_valid  out  1  outputs below are valid.
- alu_out1, alu_out2  out  WIDTH  ALU results.
- carry1, carry2  out  1  carry/borrow flags.
- diff_x  out  WIDTH  alu_out1 ^ alu_out2.
- diff_y  out  1  carry1 ^ carry2.
- mismatch  out  1  compared mismatch on this output beat.
- err_cnt  out  CNT_W  total compared mismatches, saturating.
- fault  out  1  state == FAULT.

Behaviour:
- Reset: synchronous on wb_rst_i high at the clock edge.
  - All outputs are 0 and all pipeline valids are 0.
  - err_cnt = 0, consecutive counter = 0, state = OK.
  - Reset mid-pipeline discards in-flight beats.
- ALU arithmetic is WIDTH-bit:
  - ADD: result = low WIDTH bits of A+B; carry = bit WIDTH of the sum.
  - SUB: result = A-B mod 2^WIDTH; carry = 1 iff A<B (borrow).
  - AND / OR: carry = 0.
- Stage 1 (edge after in_valid): register both results, both carries, the lockstep bit and valid.
  - fault_inj XORs ALU2's result only. It never alters carry2.
- Stage 2: register the stage-1 data onto outputs, plus diff_x and diff_y.
  - mismatch = lockstep_s1 & (diff_x != 0 | diff_y).
- Latency and throughput:
  - in_valid at cycle N gives out_valid at N+2.
  - Throughput is one beat per cycle. Bubbles propagate as out_valid = 0.
  - When out_valid = 0, data outputs hold their last value and mismatch = 0.
- Independent mode: diff_x/diff_y are still reported, but mismatch = 0 and counters/state are untouched.
- Counters update on out-beats with lockstep_s1 = 1:
  - mismatch: err_cnt increments, saturating at 2^CNT_W-1; consec increments, saturating at FAULT_THRESH.
  - match: consec = 0; err_cnt is unchanged.
- State machine (registered, fault is the decoded state):
  - OK -> DEGRADED on a compared mismatch with consec+1 < FAULT_THRESH.
  - OK or DEGRADED -> FAULT when consec+1 == FAULT_THRESH. With FAULT_THRESH = 1, OK goes straight to FAULT.
  - DEGRADED -> OK on a compared match.
  - FAULT is sticky. Only clr_err or reset leave it, to OK.
  - In FAULT, the pipeline keeps running and err_cnt keeps counting.
- clr_err: next cycle err_cnt = 0, consec = 0, state = OK.
  - A mismatch beat coinciding with clr_err is dropped (clear wins).
  - clr_err does not flush the pipeline.
- mismatch is updated in the same edge as err_cnt, so both reflect the same beat.

Decomposition:
- Shared package alu_pkg:
  - op encodings ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_AND=2'b10, ALU_OR=2'b11.
  - state encodings ST_OK, ST_DEGRADED, ST_FAULT.
- Sub-module alu_core #(WIDTH): combinational a, b, sel -> result, carry. Instantiated twice.
- Top: pipeline registers, compare logic, counters and FSM.

Test Plan:
- Reset: hold wb_rst_i 2 cycles with random inputs -> all outputs 0, fault = 0, err_cnt = 0. out_valid stays 0 until 2 cycles after the first in_valid.
- Lockstep ADD, WIDTH=4: a0=4'hF, b0=4'h1, sel1=00, in_valid at N -> at N+2 out_valid=1, alu_out1=alu_out2=4'h0, carry1=carry2=1, diff_x=0, mismatch=0.
- Independent SUB vs OR: a0=3, b0=5, sel1=01; a1=3, b1=5, sel2=11.
  - Expect alu_out1=4'hE, carry1=1, alu_out2=4'h7, diff_x=4'h9.
  - mismatch=0 and err_cnt unchanged.
- Fault threshold, FAULT_THRESH=3, lockstep, fault_inj=4'h1 on beats 1, 2, 4, 5, 6 and 0 on beat 3, back-to-back:
  - beat 3 returns state to OK.
  - fault rises with the beat-6 output.
  - err_cnt = 5.
- Saturation and stickiness, CNT_W=2: 6 injected mismatches -> err_cnt stays 3 and fault stays 1 with fault_inj=0 afterward.
- clr_err asserted in the same cycle as a mismatch out-beat -> next cycle err_cnt=0, fault=0, state OK. The coinciding mismatch is not counted.
